// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [63:0] xdata_t;

  // Architectural zero register: never written, always reads 0, never busy.
  localparam reg_addr_t X0_ADDR = 5'd0;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register.
// Issue sets a flag, a retiring write clears it; set wins on collision.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR-1:0]    wr_clr,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic [NREGS-1:0]  busy_vec
);

  localparam logic [AW-1:0] X0 = AW'(X0_ADDR);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NWR-1:0]   clr_v;

  // Effective clear per write port (x0 is never tracked).
  always_comb begin
    clr_v = '0;
    for (int p = 0; p < NWR; p++)
      clr_v[p] = wr_en[p] & wr_clr[p] & (wr_addr[p*AW +: AW] != X0);
  end

  // Next board state: clears first, then the issue set overrides them.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NWR; p++)
      if (clr_v[p]) busy_d[wr_addr[p*AW +: AW]] = 1'b0;
    if (iss_valid && iss_rd != X0) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Board register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  // Per read port lookup; a same-cycle retiring write hides the busy bit
  // because the bypass already delivers the value.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          clr_hit;

    assign ra = rd_addr[i*AW +: AW];

    // Any clearing write port aimed at this read address.
    always_comb begin
      clr_hit = 1'b0;
      for (int p = 0; p < NWR; p++)
        if (clr_v[p] && wr_addr[p*AW +: AW] == ra) clr_hit = 1'b1;
    end

    assign rd_busy[i] = busy_q[ra] & ~clr_hit & (ra != X0);
  end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Multi-ported integer register file: NRD combinational read ports with
// write-first bypass, NWR write ports (highest index wins), x0 tied to zero,
// plus a busy scoreboard for RAW hazard detection at issue.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      wr_clr,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREGS-1:0]    busy_vec
);

  localparam logic [AW-1:0] X0 = AW'(X0_ADDR);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;

  // Write ports applied in ascending order so the highest index lands last.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NWR; p++)
      if (wr_en[p] && wr_addr[p*AW +: AW] != X0)
        regs_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
    regs_d[0] = '0;
  end

  // Storage, cleared asynchronously; a write in a reset cycle is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '0;
    else      regs_q <= regs_d;
  end

  // Read ports: stored value, overridden by any matching same-cycle write.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;

    assign ra = rd_addr[i*AW +: AW];

    // Bypass mux; while in reset the cleared state is what is visible.
    always_comb begin
      rdat = regs_q[ra];
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] == ra)
          rdat = wr_data[p*XLEN +: XLEN];
      if (ra == X0 || !rst) rdat = '0;
    end

    assign rd_data[i*XLEN +: XLEN] = rdat;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_clr    (wr_clr),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .busy_vec  (busy_vec)
  );

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vectors on the default configuration and a
// reference-model run on a narrow 3-read/1-write configuration. Stimulus
// pushes expectations into a queue; a negedge monitor pops and compares.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance (64b, 32 regs, 2R/2W) ----------------
  logic         rst_a;
  logic [9:0]   rd_addr_a;
  logic [127:0] rd_data_a;
  logic [1:0]   rd_busy_a;
  logic [1:0]   wr_en_a;
  logic [9:0]   wr_addr_a;
  logic [127:0] wr_data_a;
  logic [1:0]   wr_clr_a;
  logic         iss_valid_a;
  logic [4:0]   iss_rd_a;
  logic [31:0]  busy_vec_a;

  regfile_mp dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .rd_addr   (rd_addr_a),
    .rd_data   (rd_data_a),
    .rd_busy   (rd_busy_a),
    .wr_en     (wr_en_a),
    .wr_addr   (wr_addr_a),
    .wr_data   (wr_data_a),
    .wr_clr    (wr_clr_a),
    .iss_valid (iss_valid_a),
    .iss_rd    (iss_rd_a),
    .busy_vec  (busy_vec_a)
  );

  // ---------------- narrow instance (32b, 16 regs, 3R/1W) ----------------
  logic        rst_b;
  logic [11:0] rd_addr_b;
  logic [95:0] rd_data_b;
  logic [2:0]  rd_busy_b;
  logic [0:0]  wr_en_b;
  logic [3:0]  wr_addr_b;
  logic [31:0] wr_data_b;
  logic [0:0]  wr_clr_b;
  logic        iss_valid_b;
  logic [3:0]  iss_rd_b;
  logic [15:0] busy_vec_b;

  regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3), .NWR(1)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .rd_addr   (rd_addr_b),
    .rd_data   (rd_data_b),
    .rd_busy   (rd_busy_b),
    .wr_en     (wr_en_b),
    .wr_addr   (wr_addr_b),
    .wr_data   (wr_data_b),
    .wr_clr    (wr_clr_b),
    .iss_valid (iss_valid_b),
    .iss_rd    (iss_rd_b),
    .busy_vec  (busy_vec_b)
  );

  // ---------------- scoreboard ----------------
  // kind: 0 rd_data_a[idx], 1 rd_busy_a[idx], 2 busy_vec_a[idx], 3 busy_vec_a,
  //       4 rd_data_b[idx], 5 rd_busy_b[idx], 6 busy_vec_b
  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [63:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic push(input string name, input int kind, input int idx,
                      input logic [63:0] exp);
    exp_t e;
    e.name = name; e.kind = kind; e.idx = idx; e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic chk_now(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every expectation queued this cycle is checked mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = rd_data_a[e.idx*64 +: 64];
        1:       act = {63'b0, rd_busy_a[e.idx]};
        2:       act = {63'b0, busy_vec_a[e.idx]};
        3:       act = {32'b0, busy_vec_a};
        4:       act = {32'b0, rd_data_b[e.idx*32 +: 32]};
        5:       act = {63'b0, rd_busy_b[e.idx]};
        default: act = {48'b0, busy_vec_b};
      endcase
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: actual %h required %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    n_chk++;
    n_fail++;
    $display("FAIL timeout: run did not finish within the time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    wr_en_a = '0; wr_addr_a = '0; wr_data_a = '0; wr_clr_a = '0;
    iss_valid_a = 1'b0; iss_rd_a = '0;
  endtask

  task automatic wr_a(input int p, input logic [4:0] a, input logic [63:0] d,
                      input logic clr);
    wr_en_a[p] = 1'b1;
    wr_addr_a[p*5 +: 5] = a;
    wr_data_a[p*64 +: 64] = d;
    wr_clr_a[p] = clr;
  endtask

  task automatic rd_a(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr_a = {a1, a0};
  endtask

  // ---------------- directed sequence on the default instance ----------------
  task automatic run_a();
    rst_a = 1'b0; idle_a(); rd_a(5'd0, 5'd0);
    #1;
    chk_now("rst_now_rd0", rd_data_a[63:0], 64'h0);
    chk_now("rst_now_busy", {32'b0, busy_vec_a}, 64'h0);
    push("rst_rd0", 0, 0, 64'h0);
    push("rst_rd1", 0, 1, 64'h0);
    push("rst_busy", 3, 0, 64'h0);
    tick();
    rst_a = 1'b1;
    tick();

    // x5 = DEAD, bypassed in the same cycle
    idle_a(); wr_a(0, 5'd5, 64'hDEAD, 1'b0); rd_a(5'd5, 5'd1);
    push("byp_x5", 0, 0, 64'hDEAD);
    tick();
    idle_a(); iss_valid_a = 1'b1; iss_rd_a = 5'd5;
    push("rd_x5", 0, 0, 64'hDEAD);
    tick();

    // mid-run reset with a write in flight: everything reads cleared
    idle_a(); rst_a = 1'b0; wr_a(0, 5'd5, 64'hBEEF, 1'b0); rd_a(5'd5, 5'd5);
    push("mrst_rd0", 0, 0, 64'h0);
    push("mrst_rd1", 0, 1, 64'h0);
    push("mrst_busy", 3, 0, 64'h0);
    tick();
    idle_a(); rst_a = 1'b1;
    tick();
    push("post_rst_x5", 0, 0, 64'h0);
    push("post_rst_busy5", 2, 5, 64'h0);
    tick();

    // x31 written then reset again
    idle_a(); wr_a(1, 5'd31, 64'h1, 1'b0); rd_a(5'd0, 5'd0);
    tick();
    idle_a(); rd_a(5'd31, 5'd31);
    push("rd_x31", 0, 1, 64'h1);
    tick();
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    push("rst_x31", 0, 0, 64'h0);
    tick();
    push("rel_x31", 0, 0, 64'h0);
    tick();

    // basic write/read on both ports
    idle_a(); wr_a(0, 5'd7, 64'h0123_4567_89AB_CDEF, 1'b0);
    tick();
    idle_a(); rd_a(5'd7, 5'd7);
    push("rd0_x7", 0, 0, 64'h0123_4567_89AB_CDEF);
    push("rd1_x7", 0, 1, 64'h0123_4567_89AB_CDEF);
    tick();

    // x0 write dropped, never bypassed
    idle_a(); wr_a(0, 5'd0, 64'hFFFF, 1'b1); rd_a(5'd0, 5'd0);
    push("byp_x0", 0, 0, 64'h0);
    push("busy_x0", 1, 0, 64'h0);
    tick();
    idle_a();
    push("rd_x0", 0, 1, 64'h0);
    tick();

    // two ports to x3: port1 wins, in bypass and in storage
    idle_a(); wr_a(0, 5'd3, 64'hA, 1'b0); wr_a(1, 5'd3, 64'hB, 1'b0);
    rd_a(5'd3, 5'd3);
    push("conf_byp0", 0, 0, 64'hB);
    push("conf_byp1", 0, 1, 64'hB);
    tick();
    idle_a();
    push("conf_x3", 0, 0, 64'hB);
    tick();

    // port0-only bypass
    idle_a(); wr_a(0, 5'd4, 64'hC, 1'b0); rd_a(5'd4, 5'd3);
    push("byp_x4", 0, 0, 64'hC);
    push("keep_x3", 0, 1, 64'hB);
    tick();

    // scoreboard lifecycle on x9
    idle_a(); iss_valid_a = 1'b1; iss_rd_a = 5'd9; rd_a(5'd9, 5'd9);
    push("busy9_pre_iss", 1, 0, 64'h0);
    tick();
    idle_a();
    push("busy_vec9_set", 2, 9, 64'h1);
    push("rd_busy9", 1, 0, 64'h1);
    tick();
    idle_a(); wr_a(0, 5'd9, 64'h99, 1'b1);
    push("clr_rd_busy9", 1, 0, 64'h0);
    push("clr_other_port", 1, 1, 64'h0);
    push("clr_data9", 0, 0, 64'h99);
    push("busy_vec9_pre", 2, 9, 64'h1);
    tick();
    idle_a();
    push("busy_vec9_clr", 2, 9, 64'h0);
    push("rd_x9", 0, 1, 64'h99);
    tick();

    // issue and retiring write collide on x12: set wins
    idle_a(); iss_valid_a = 1'b1; iss_rd_a = 5'd12;
    wr_a(1, 5'd12, 64'h1212, 1'b1); rd_a(5'd12, 5'd12);
    tick();
    idle_a(); iss_valid_a = 1'b1; iss_rd_a = 5'd0;
    push("coll_busy12", 2, 12, 64'h1);
    push("coll_data12", 0, 0, 64'h1212);
    push("coll_rd_busy12", 1, 1, 64'h1);
    tick();
    idle_a();
    push("iss_x0_busy0", 2, 0, 64'h0);
    push("busy_vec_final", 3, 0, 64'h0000_0000_0000_1000);
    tick();
  endtask

  // ---------------- random traffic on the narrow instance ----------------
  task automatic run_b();
    logic [31:0] m_regs [16];
    logic [15:0] m_busy;
    logic [3:0]  ra;
    logic [31:0] ed;
    logic        eb;

    for (int r = 0; r < 16; r++) m_regs[r] = '0;
    m_busy = '0;
    rst_b = 1'b0; wr_en_b = '0; wr_addr_b = '0; wr_data_b = '0; wr_clr_b = '0;
    iss_valid_b = 1'b0; iss_rd_b = '0; rd_addr_b = '0;
    tick();
    rst_b = 1'b1;
    tick();

    for (int c = 0; c < 10000; c++) begin
      wr_en_b[0]  = 1'($urandom_range(0, 1));
      wr_addr_b   = 4'($urandom_range(0, 15));
      wr_data_b   = $urandom;
      wr_clr_b[0] = 1'($urandom_range(0, 1));
      iss_valid_b = 1'($urandom_range(0, 1));
      iss_rd_b    = 4'($urandom_range(0, 15));
      for (int i = 0; i < 3; i++) begin
        // bias reads toward the write address to exercise bypass often
        ra = ($urandom_range(0, 3) == 0) ? wr_addr_b : 4'($urandom_range(0, 15));
        rd_addr_b[i*4 +: 4] = ra;
        if (ra == 4'd0)                        ed = '0;
        else if (wr_en_b[0] && wr_addr_b == ra) ed = wr_data_b;
        else                                   ed = m_regs[ra];
        eb = (ra != 4'd0) && m_busy[ra] &&
             !(wr_en_b[0] && wr_clr_b[0] && wr_addr_b == ra);
        push($sformatf("rnd_c%0d_data%0d", c, i), 4, i, {32'b0, ed});
        push($sformatf("rnd_c%0d_busy%0d", c, i), 5, i, {63'b0, eb});
      end
      push($sformatf("rnd_c%0d_busy_vec", c), 6, 0, {48'b0, m_busy});
      tick();
      if (wr_en_b[0] && wr_addr_b != 4'd0) m_regs[wr_addr_b] = wr_data_b;
      if (wr_en_b[0] && wr_clr_b[0] && wr_addr_b != 4'd0) m_busy[wr_addr_b] = 1'b0;
      if (iss_valid_b && iss_rd_b != 4'd0) m_busy[iss_rd_b] = 1'b1;
    end
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    @(negedge clk);
    #1;
    chk_now("exp_q_drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised integer register file for the npc-riscv64 core.
- Sits between decode/issue and writeback.
- Provides NRD combinational read ports and NWR synchronous write ports, with write-to-read bypass and x0 hardwired to zero.
- Includes a per-register busy scoreboard so issue can detect RAW hazards on pending writes.

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two.
- AW, $clog2(NREGS), register address width (derived).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports; a higher port index has higher priority.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data per port.
- rd_busy  out  NRD  scoreboard busy bit of each read address, after bypass.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- wr_clr  in  NWR  per-port flag: this write retires a pending scoreboard entry.
- iss_valid  in  1  an instruction with a destination register issues this cycle.
- iss_rd  in  AW  destination of the issuing instruction.
- busy_vec  out  NREGS  full scoreboard state, for debug and stall logic.

Behaviour:
- Reset (rst low, asynchronous):
  - All NREGS registers go to 0, including index NREGS-1.
  - busy_vec goes to 0.
  - Outputs follow combinationally from the cleared state: rd_data=0, rd_busy=0.
  - Reset asserted mid-operation discards any write in that cycle.
  - Release is sampled at the next rising clk edge.
- Writes: on the rising clk edge, for each port p with wr_en[p]=1 and wr_addr[p]!=0, set regs[wr_addr[p]] <= wr_data[p].
- Write conflict: when several ports target the same address in one cycle, the highest-index port wins. No error is flagged.
- x0:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 and rd_busy=0 regardless of other inputs.
- Reads are combinational, with zero-cycle latency.
- Bypass (write-first): if any enabled write port in the same cycle targets rd_addr[i]!=0, rd_data[i] returns that port's wr_data; the highest-index port wins among several matches. Otherwise rd_data[i] returns the stored value.
- Scoreboard update, at the rising edge:
  - clear: for each p with wr_en[p] & wr_clr[p] & wr_addr[p]!=0, busy[wr_addr[p]] <= 0.
  - set: if iss_valid & iss_rd!=0, busy[iss_rd] <= 1.
  - If set and clear hit the same register in the same cycle, set wins: the old producer retires and the new producer is pending.
  - Clearing an already-clear entry is harmless.
  - Setting an already-busy entry keeps it at 1 (WAW on a single-bit board).
- rd_busy[i] = busy[rd_addr[i]] & ~(a same-cycle clearing write to rd_addr[i]). The bypassed value is valid that cycle, so no stall is needed.
- rd_busy does not reflect a same-cycle iss_valid; issue logic handles self-dependence.
- No $display or other simulation side-effects in synthesizable code. A debug dump, if needed, is a bench task reading busy_vec and hierarchical regs.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEFAULT=64, NREGS_DEFAULT=32.
  - typedef reg_addr_t (logic [4:0]) and xdata_t (logic [63:0]).
  - Constant X0_ADDR=0.
- Sub-module regfile_scoreboard: busy bit array, set/clear priority, and the rd_busy lookup per port.
- Storage array, write-port priority and the bypass mux stay in regfile_mp, with a generate loop per read port.

Test Plan:
- Reset: drive rst low mid-run after writing x5=0xDEAD → all rd_data=0, busy_vec=0. Write x31=0x1 and reset again → x31 reads 0.
- Basic write/read: write x7=0x0123_4567_89AB_CDEF on port0, then read x7 on both read ports the next cycle → both return the value. Write x0=0xFFFF → x0 reads 0.
- Bypass and conflict:
  - Same cycle, port0 writes x3=0xA and port1 writes x3=0xB, with rd_addr[0]=3 → rd_data[0]=0xB.
  - Next cycle, x3 reads 0xB.
  - Port0-only write x4=0xC with rd_addr=4 → 0xC in the same cycle.
- Scoreboard lifecycle:
  - iss_valid, iss_rd=9 → busy_vec[9]=1 next cycle, and rd_busy=1 when reading x9.
  - Write x9 with wr_clr=1: same-cycle rd_busy=0, rd_data equals the new value, busy_vec[9]=0 after the edge.
- Set/clear collision: same cycle, iss_rd=12 and wr_en/wr_clr to x12 → busy_vec[12]=1 after the edge, and x12 holds the written data. iss_rd=0 → busy_vec[0] stays 0.
- Parameter sweep: XLEN=32, NREGS=16, NRD=3, NWR=1 → re-run the scenarios above with random traffic against a reference model: 10k cycles, zero mismatches.
